seven_segment_scan_reader: RTL and testbench

SEVEN_SEGMENT_SCAN_READER -- requirements
Module: seven_segment_scan_reader

---
 rtl/seven_segment_scan_reader.sv | 135 +++++++++++++
 tb/tb_seven_segment_scan_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_reader.sv
// seven_segment_scan_reader
//   Recovers the hex value shown on a multiplexed, active-low 4-digit
//   seven-segment display by watching its segment and digit-enable lines.
//   Each digit is captured once its pattern has stayed unchanged long enough.
//   A full set of four captured digits forms one frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seg_n[6:0]   active-low segments {g,f,e,d,c,b,a}
//   an_n[3:0]    active-low digit enables, [3] = leftmost
//   hex_value    last good frame, nibble i = digit i
//   value_valid  one-cycle pulse when hex_value updates
//   frame_error  one-cycle pulse when a completed frame is discarded
module seven_segment_scan_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] hex_value,
  output logic        value_valid,
  output logic        frame_error
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_HIT = 4'(STABLE_CYCLES - 1);

  logic [10:0] samp;
  logic [3:0]  cnt;
  logic [3:0]  mask, mask_nx;
  logic        err, err_nx;
  logic [15:0] nib, nib_nx;

  logic        same;
  logic        strobe;
  logic [3:0]  an_act;
  logic        one_digit;
  logic [4:0]  dec;

  // {legal, nibble}
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign same      = ({an_n, seg_n} == samp);
  assign strobe    = same && (cnt == CNT_HIT);
  // During a strobe the inputs equal the sample, so decode the sample.
  assign an_act    = ~samp[10:7];
  assign one_digit = (an_act != 4'h0) && ((an_act & (an_act - 4'h1)) == 4'h0);
  assign dec       = decode(samp[6:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp <= 11'h7FF;
      cnt  <= 4'h0;
    end else begin
      samp <= {an_n, seg_n};
      if (!same)
        cnt <= 4'h0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 4'h1;
    end
  end

  always_comb begin
    mask_nx = mask;
    err_nx  = err;
    nib_nx  = nib;
    // Completion clears the frame first so a coinciding strobe opens the next one.
    if (mask == 4'hF) begin
      mask_nx = 4'h0;
      err_nx  = 1'b0;
    end
    if (strobe) begin
      if (one_digit) begin
        for (int i = 0; i < 4; i++) begin
          if (an_act[i]) begin
            nib_nx[i*4 +: 4] = dec[4] ? dec[3:0] : 4'h0;
            mask_nx[i]       = 1'b1;
            if (!dec[4])
              err_nx = 1'b1;
          end
        end
      end else if (an_act != 4'h0) begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask        <= 4'h0;
      err         <= 1'b0;
      nib         <= 16'h0000;
      hex_value   <= 16'h0000;
      value_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      mask        <= mask_nx;
      err         <= err_nx;
      nib         <= nib_nx;
      value_valid <= 1'b0;
      frame_error <= 1'b0;
      if (mask == 4'hF) begin
        if (!err) begin
          hex_value   <= nib;
          value_valid <= 1'b1;
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// tb_seven_segment_scan_reader
//   Directed stimulus for seven_segment_scan_reader (STABLE_CYCLES = 4).
//   Expected frame outcomes are queued when the last digit of a frame is
//   applied; a monitor pops and compares whenever a pulse appears.
module tb_seven_segment_scan_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] hex_value;
  logic        value_valid;
  logic        frame_error;

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    int          edge_no;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  bit   prev_pulse = 0;

  seven_segment_scan_reader #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .hex_value   (hex_value),
    .value_valid (value_valid),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit pulse;
    pulse = value_valid || frame_error;
    if (pulse) begin
      chk("pulse_exclusive", {31'd0, value_valid && frame_error}, 32'd0);
      chk("pulse_not_consecutive", {31'd0, prev_pulse}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {31'd0, frame_error}, {31'd0, value_valid});
        chk("unexpected_pulse_present", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind_is_err", {31'd0, frame_error}, {31'd0, e.is_err});
        chk("hex_value", {16'd0, hex_value}, {16'd0, e.val});
        chk("pulse_edge", edge_cnt, e.edge_no);
      end
    end
    prev_pulse = pulse;
  end

  // kind: 0 = no expectation, 1 = value_valid, 2 = frame_error
  task automatic dig(input logic [3:0] an, input logic [6:0] seg, input int n,
                     input int kind = 0, input logic [15:0] val = 16'h0);
    an_n  = an;
    seg_n = seg;
    if (kind != 0) begin
      exp_t e;
      e.is_err  = (kind == 2);
      e.val     = val;
      e.edge_no = edge_cnt + 6; // STABLE_CYCLES + 2
      q.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dig(4'hF, 7'h7F, n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hex", {16'd0, hex_value}, 32'h0);
    chk("reset_valid", {31'd0, value_valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(20);
    chk("idle_hex", {16'd0, hex_value}, 32'h0);

    // Good frame 1234
    dig(4'h7, 7'h79, 6);
    dig(4'hB, 7'h24, 6);
    dig(4'hD, 7'h30, 6);
    dig(4'hE, 7'h19, 6, 1, 16'h1234);
    idle(4);
    chk("frame1_hex", {16'd0, hex_value}, 32'h1234);

    // Digit 1 blank -> discarded, value held
    dig(4'h7, 7'h79, 6);
    dig(4'hB, 7'h24, 6);
    dig(4'hD, 7'h7F, 6);
    dig(4'hE, 7'h19, 6, 2, 16'h1234);
    idle(4);
    chk("blank_hold_hex", {16'd0, hex_value}, 32'h1234);

    // Two enables low inside an otherwise legal frame
    dig(4'h7, 7'h79, 6);
    dig(4'hC, 7'h79, 6);
    dig(4'hB, 7'h24, 6);
    dig(4'hD, 7'h30, 6);
    dig(4'hE, 7'h19, 6, 2, 16'h1234);
    idle(4);

    // Recapture overwrites digit 0 (E then F), order free -> 567F
    dig(4'hE, 7'h06, 6);
    dig(4'hE, 7'h0E, 6);
    dig(4'h7, 7'h12, 6);
    dig(4'hB, 7'h02, 6);
    dig(4'hD, 7'h78, 6, 1, 16'h567F);
    idle(4);
    chk("recapture_hex", {16'd0, hex_value}, 32'h567F);

    // Digit 3 held only 4 edges -> never captured, frame never completes
    dig(4'h7, 7'h79, 4);
    dig(4'hB, 7'h24, 6);
    dig(4'hD, 7'h30, 6);
    dig(4'hE, 7'h19, 6);
    idle(10);

    // Reset discards partial frame (including the one above)
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_pulse_hex", {16'd0, hex_value}, 32'h0);
    dig(4'h7, 7'h00, 6);
    dig(4'hB, 7'h10, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dig(4'hD, 7'h08, 6);
    dig(4'hE, 7'h03, 6);
    idle(10);
    chk("partial_no_update", {16'd0, hex_value}, 32'h0);
    dig(4'h7, 7'h46, 6);
    dig(4'hB, 7'h21, 6, 1, 16'hCDAB);
    idle(10);
    chk("after_reset_hex", {16'd0, hex_value}, 32'hCDAB);

    chk("missing_pulses", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
